// File: rtl/uart_baud_ctrl.sv
// Runtime-configurable baud tick generator for the UART rx (16x) and tx (1x) engines.
// The divisor is host-loaded or measured from the start bit of a received 0x55.
module uart_baud_ctrl #(
   parameter int CLOCK_RATE     = 100000000,
   parameter int DEFAULT_BAUD   = 9600,
   parameter int DIV_WIDTH      = 16,
   parameter int MIN_BIT_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 autobaud_start,
   input  logic                 cfg_load,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 rx_tick,
   output logic                 tx_tick,
   output logic [DIV_WIDTH-1:0] div_value,
   output logic                 busy,
   output logic                 locked,
   output logic                 error
);

   localparam int MEAS_WIDTH = DIV_WIDTH + 4;
   localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(CLOCK_RATE / (16 * DEFAULT_BAUD));
   localparam logic [MEAS_WIDTH-1:0] MEAS_MIN = MEAS_WIDTH'(MIN_BIT_CYCLES);
   localparam logic [MEAS_WIDTH-1:0] MEAS_SAT = '1;

   typedef enum logic [2:0] {IDLE, ARM, WAIT_FALL, MEASURE, APPLY} stateT;

   stateT                 stateReg, stateNext;
   logic                  rxMeta, rxS;
   logic [MEAS_WIDTH-1:0] measReg, measNext;
   logic [DIV_WIDTH-1:0]  divReg, divNext;
   logic                  lockedReg, lockedNext;
   logic                  errorReg, errorNext;
   logic                  applyDiv;
   logic [DIV_WIDTH-1:0]  tickCntReg;
   logic [3:0]            subReg;
   logic [MEAS_WIDTH:0]   measSum;
   logic [MEAS_WIDTH:0]   roundedWide;
   logic [DIV_WIDTH-1:0]  measDiv;

   function automatic logic [DIV_WIDTH-1:0] clampDiv(input logic [DIV_WIDTH-1:0] v);
      return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxS    <= rxMeta;
      end
   end

   // Rounded divide by 16; a quotient too wide for the divisor saturates rather than wrapping.
   always_comb begin
      measSum     = {1'b0, measReg} + (MEAS_WIDTH + 1)'(8);
      roundedWide = measSum >> 4;
      measDiv     = (|roundedWide[MEAS_WIDTH:DIV_WIDTH]) ? '1 : roundedWide[DIV_WIDTH-1:0];
   end

   always_comb begin
      stateNext  = stateReg;
      measNext   = measReg;
      divNext    = divReg;
      lockedNext = lockedReg;
      errorNext  = errorReg;
      applyDiv   = 1'b0;
      case (stateReg)
         IDLE: begin
            if (autobaud_start) begin
               stateNext  = ARM;
               lockedNext = 1'b0;
               errorNext  = 1'b0;
            end
         end
         ARM: begin
            if (rxS) stateNext = WAIT_FALL;
         end
         WAIT_FALL: begin
            if (!rxS) begin
               stateNext = MEASURE;
               measNext  = MEAS_WIDTH'(1);
            end
         end
         MEASURE: begin
            if (rxS) stateNext = APPLY;
            else if (measReg != MEAS_SAT) measNext = measReg + 1'b1;
         end
         APPLY: begin
            stateNext = IDLE;
            if (measReg < MEAS_MIN || measReg == MEAS_SAT) begin
               errorNext = 1'b1;
            end else begin
               divNext    = clampDiv(measDiv);
               lockedNext = 1'b1;
               applyDiv   = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
      // Host load overrides everything, including a measurement in flight.
      if (cfg_load) begin
         stateNext  = IDLE;
         divNext    = clampDiv(cfg_div);
         lockedNext = 1'b1;
         errorNext  = 1'b0;
         applyDiv   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg  <= IDLE;
         measReg   <= '0;
         divReg    <= DEF_DIV;
         lockedReg <= 1'b0;
         errorReg  <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         measReg   <= measNext;
         divReg    <= divNext;
         lockedReg <= lockedNext;
         errorReg  <= errorNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tickCntReg <= '0;
         subReg     <= '0;
      end else if (applyDiv) begin
         tickCntReg <= '0;
         subReg     <= '0;
      end else if (rx_tick) begin
         tickCntReg <= '0;
         subReg     <= subReg + 1'b1;
      end else begin
         tickCntReg <= tickCntReg + 1'b1;
      end
   end

   assign rx_tick   = (tickCntReg == divReg - 1'b1);
   assign tx_tick   = rx_tick && (subReg == 4'd15);
   assign div_value = divReg;
   assign busy      = (stateReg != IDLE);
   assign locked    = lockedReg;
   assign error     = errorReg;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: a cycle-level tick schedule model feeds a queue
// that a free-running monitor drains whenever the DUT raises rx_tick.
module tb_uart_baud_ctrl;

   localparam int DIV_W   = 16;
   localparam int DEF_DIV = 100000000 / (16 * 9600);
   localparam int MIN_BIT = 32;
   localparam longint NEVER = 64'h7fff_ffff_ffff;

   logic             clk;
   logic             rst_n;
   logic             rx;
   logic             autobaud_start;
   logic             cfg_load;
   logic [DIV_W-1:0] cfg_div;
   logic             rx_tick;
   logic             tx_tick;
   logic [DIV_W-1:0] div_value;
   logic             busy;
   logic             locked;
   logic             error;

   uart_baud_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .autobaud_start(autobaud_start),
      .cfg_load(cfg_load), .cfg_div(cfg_div), .rx_tick(rx_tick), .tx_tick(tx_tick),
      .div_value(div_value), .busy(busy), .locked(locked), .error(error)
   );

   typedef struct {longint cyc; bit tx;} tickExpT;
   typedef struct {longint cyc; int div;} applyT;

   tickExpT tickQ[$];
   applyT   applyQ[$];
   longint  cyc;
   longint  nextTick;
   int      schedDiv;
   int      tickIdx;
   int      checks;
   int      failures;
   int      mDiv;
   bit      mLocked, mError, mBusy;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected tick schedule: after each divisor apply, ticks at apply+div-1, +div, ...
   // and every 16th tick since the apply also carries tx_tick.
   initial begin
      tickExpT e;
      cyc      = 0;
      nextTick = NEVER;
      schedDiv = DEF_DIV;
      tickIdx  = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (applyQ.size() > 0 && applyQ[0].cyc == cyc) begin
            schedDiv = applyQ[0].div;
            nextTick = cyc + schedDiv - 1;
            tickIdx  = 0;
            void'(applyQ.pop_front());
         end
         if (cyc == nextTick) begin
            e.cyc = cyc;
            e.tx  = ((tickIdx % 16) == 15);
            tickQ.push_back(e);
            tickIdx  = tickIdx + 1;
            nextTick = nextTick + schedDiv;
         end
      end
   end

   initial begin
      tickExpT e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n === 1'b1) begin
            while (tickQ.size() > 0 && tickQ[0].cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL missed_rx_tick at cycle %0d: got rx_tick=0, required 1", tickQ[0].cyc);
               void'(tickQ.pop_front());
            end
            if (rx_tick === 1'b1) begin
               checks++;
               if (tickQ.size() > 0 && tickQ[0].cyc == cyc) begin
                  e = tickQ.pop_front();
                  if (tx_tick !== e.tx) begin
                     failures++;
                     $display("FAIL tx_tick at cycle %0d: got %b, required %b", cyc, tx_tick, e.tx);
                  end
               end else begin
                  failures++;
                  $display("FAIL unexpected_rx_tick at cycle %0d: got 1, required 0 (div_value=%0d)", cyc, div_value);
               end
            end else if (rx_tick !== 1'b0 || tx_tick !== 1'b0) begin
               checks++;
               failures++;
               $display("FAIL tick_idle at cycle %0d: got rx_tick=%b tx_tick=%b, required 0/0", cyc, rx_tick, tx_tick);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   task automatic checkStatus(input string tag);
      check({tag, "_div_value"}, 32'(div_value), 32'(mDiv));
      check({tag, "_locked"}, 32'(locked), 32'(mLocked));
      check({tag, "_error"}, 32'(error), 32'(mError));
      check({tag, "_busy"}, 32'(busy), 32'(mBusy));
   endtask

   function automatic int clampDiv(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic modelApply(input longint atCyc, input int div);
      applyT a;
      a.cyc = atCyc;
      a.div = div;
      applyQ.push_back(a);
      mDiv = div;
   endtask

   // Assert reset mid-cycle and verify outputs before any clock edge.
   task automatic doReset(input int holdCycles);
      @(negedge clk);
      rst_n = 1'b0;
      tickQ.delete();
      applyQ.delete();
      nextTick = NEVER;
      mDiv = DEF_DIV; mLocked = 1'b0; mError = 1'b0; mBusy = 1'b0;
      #1;
      checkStatus("reset_async");
      check("reset_rx_tick", 32'(rx_tick), 32'd0);
      check("reset_tx_tick", 32'(tx_tick), 32'd0);
      repeat (holdCycles) @(negedge clk);
      rx = 1'b1;
      rst_n = 1'b1;
      schedDiv = DEF_DIV;
      tickIdx  = 0;
      nextTick = cyc + DEF_DIV - 1;
      $display("txn reset released cycle=%0d", cyc);
   endtask

   task automatic doCfgLoad(input int v, input bit withStart);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_div = DIV_W'(v);
      autobaud_start = withStart;
      modelApply(cyc + 1, clampDiv(v));
      mLocked = 1'b1; mError = 1'b0; mBusy = 1'b0;
      @(negedge clk);
      cfg_load = 1'b0;
      autobaud_start = 1'b0;
      $display("txn cfg_load cfg_div=%0d start=%0d cycle=%0d", v, withStart, cyc);
      checkStatus("cfg_load");
   endtask

   task automatic doAutobaud(input int lowLen, input bit sendFrame);
      longint riseCyc;
      bit accept;
      int newDiv;
      logic [7:0] frame;
      @(negedge clk);
      autobaud_start = 1'b1;
      mBusy = 1'b1; mLocked = 1'b0; mError = 1'b0;
      @(negedge clk);
      autobaud_start = 1'b0;
      checkStatus("ab_armed");
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (lowLen) @(negedge clk);
      check("ab_busy_measuring", 32'(busy), 32'd1);
      rx = 1'b1;
      riseCyc = cyc;
      accept = (lowLen >= MIN_BIT);
      newDiv = clampDiv((lowLen + 8) / 16);
      // Two synchronizer cycles, one APPLY cycle, then the new divisor is live.
      if (accept) begin
         modelApply(riseCyc + 4, newDiv);
         mLocked = 1'b1;
      end else begin
         mError = 1'b1;
      end
      repeat (2) @(negedge clk);
      check("ab_busy_before_apply", 32'(busy), 32'd1);
      mBusy = 1'b0;
      repeat (3) @(negedge clk);
      $display("txn autobaud low=%0d accept=%0d expected_div=%0d cycle=%0d", lowLen, accept, mDiv, cyc);
      checkStatus("autobaud");
      if (sendFrame) begin
         frame = 8'h55;
         repeat (lowLen - 5) @(negedge clk);
         for (int b = 0; b < 8; b++) begin
            rx = frame[b];
            repeat (lowLen) @(negedge clk);
         end
         rx = 1'b1;
         repeat (lowLen) @(negedge clk);
         checkStatus("ab_after_frame");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rx = 1'b1;
      autobaud_start = 1'b0;
      cfg_load = 1'b0;
      cfg_div = '0;
      checks = 0;
      failures = 0;
      mDiv = DEF_DIV; mLocked = 1'b0; mError = 1'b0; mBusy = 1'b0;

      doReset(3);
      repeat (20000) @(negedge clk);
      checkStatus("idle_default");

      doCfgLoad(54, 1'b0);
      repeat (2000) @(negedge clk);
      doCfgLoad(1, 1'b0);
      repeat (200) @(negedge clk);
      doCfgLoad(0, 1'b0);
      repeat (100) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         doCfgLoad(int'($urandom_range(0, 150)), 1'b0);
         repeat ($urandom_range(30, 1500)) @(negedge clk);
      end
      doCfgLoad(37, 1'b0);
      repeat (20) @(negedge clk);
      doCfgLoad(37, 1'b0);
      repeat (700) @(negedge clk);

      doAutobaud(868, 1'b1);
      repeat (1000) @(negedge clk);

      doReset(2);
      repeat (50) @(negedge clk);
      doAutobaud(20, 1'b0);
      repeat (700) @(negedge clk);
      doAutobaud(31, 1'b0);
      repeat (200) @(negedge clk);
      doAutobaud(32, 1'b0);
      repeat (200) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         doAutobaud(int'($urandom_range(20, 1200)), 1'b0);
         repeat ($urandom_range(100, 1200)) @(negedge clk);
      end

      // Line already low: the measurement must never leave ARM.
      @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      autobaud_start = 1'b1;
      mBusy = 1'b1; mLocked = 1'b0; mError = 1'b0;
      @(negedge clk);
      autobaud_start = 1'b0;
      repeat (50) @(negedge clk);
      $display("txn autobaud with rx held low cycle=%0d", cyc);
      checkStatus("stuck_arm");
      doCfgLoad(100, 1'b0);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      checkStatus("after_abort");
      repeat (300) @(negedge clk);

      @(negedge clk);
      autobaud_start = 1'b1;
      @(negedge clk);
      autobaud_start = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b0;
      repeat (100) @(negedge clk);
      check("mid_measure_busy", 32'(busy), 32'd1);
      $display("txn reset during measurement cycle=%0d", cyc);
      doReset(3);
      repeat (1400) @(negedge clk);
      checkStatus("after_mid_reset");

      doCfgLoad(77, 1'b1);
      repeat (3) @(negedge clk);
      checkStatus("simultaneous");
      repeat (2000) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
